// File: rtl/ddr3_mem_resp.sv
// DDR3-style memory responder. It decodes the command bus, tracks the open row of
// each bank, runs one BL8 read or write burst at a time and keeps a sticky error flag.
module ddr3_mem_resp #(
  parameter int CL    = 5,
  parameter int CWL   = 5,
  parameter int ROW_W = 4,
  parameter int COL_W = 6
) (
  input  logic        cpu_clk,
  input  logic        RESET_N,
  input  logic        CKE_N,
  input  logic        CS_N,
  input  logic        RAS_N,
  input  logic        CAS_N,
  input  logic        WE_N,
  input  logic [2:0]  BA,
  input  logic [14:0] ADDR,
  input  logic [7:0]  DQ_IN,
  output logic [7:0]  DQ_OUT,
  output logic        DQ_OE,
  output logic        INIT_DONE,
  output logic [7:0]  BANK_OPEN,
  output logic        ERR
);
  localparam int MEM_AW = 3 + ROW_W + COL_W;

  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_ZQC = 4'b0110;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_READY} state_t;
  state_t state_q, state_d;

  logic [3:0]       cmd;
  logic             live, is_act, is_pre, is_ref, is_rw;
  logic             init_err, act_err, ref_err, rw_err, accept;
  logic [7:0]       open_eff, bank_open_d;

  logic             busy, b_wr, b_ap;
  logic [4:0]       cnt, b_lat;
  logic [2:0]       b_bank;
  logic [ROW_W-1:0] b_row;
  logic [COL_W-1:0] b_col;
  logic             ap_clr;
  logic [2:0]       ap_bank;
  logic             in_window;
  logic [2:0]       beat;
  logic [MEM_AW-1:0] mem_addr;

  logic [7:0]       mem [2**MEM_AW];
  logic [ROW_W-1:0] open_row [8];
  logic             unused_addr;

  assign unused_addr = ^ADDR;

  assign cmd    = {CS_N, RAS_N, CAS_N, WE_N};
  assign live   = CKE_N && (state_q == ST_READY);
  assign is_act = live && (cmd == CMD_ACT);
  assign is_pre = live && (cmd == CMD_PRE);
  assign is_ref = live && (cmd == CMD_REF);
  assign is_rw  = live && ((cmd == CMD_WR) || (cmd == CMD_RD));

  // A pending auto-precharge takes effect this cycle, so all checks see it as closed.
  assign open_eff = ap_clr ? (BANK_OPEN & ~(8'd1 << ap_bank)) : BANK_OPEN;

  assign init_err = CKE_N && (state_q == ST_INIT) &&
                    !(CS_N || (cmd == CMD_MRS) || (cmd == CMD_NOP) || (cmd == CMD_ZQC));
  assign act_err  = is_act && (open_eff[BA] || (busy && b_ap && (b_bank == BA)));
  assign ref_err  = is_ref && (open_eff != 8'd0);
  assign rw_err   = is_rw && (busy || !open_eff[BA]);
  assign accept   = is_rw && !rw_err;

  assign in_window = busy && (cnt >= b_lat) && (cnt <= b_lat + 5'd7);
  assign beat      = 3'(cnt - b_lat);
  assign mem_addr  = {b_bank, b_row, b_col | COL_W'(beat)};
  assign INIT_DONE = (state_q == ST_READY);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: if (CKE_N) state_d = ST_INIT;
      ST_INIT:  if (CKE_N && (cmd == CMD_ZQC)) state_d = ST_READY;
      default:  state_d = state_q;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    bank_open_d = open_eff;
    if (is_act && !act_err) bank_open_d[BA] = 1'b1;
    if (is_pre) begin
      if (ADDR[10]) bank_open_d = 8'd0;
      else          bank_open_d[BA] = 1'b0;
    end
  end

  // cnt holds the number of cycles since the burst command was accepted.
  always_ff @(posedge cpu_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      BANK_OPEN <= 8'd0;
      ERR       <= 1'b0;
      DQ_OE     <= 1'b0;
      DQ_OUT    <= 8'd0;
      busy      <= 1'b0;
      cnt       <= 5'd0;
      b_wr      <= 1'b0;
      b_ap      <= 1'b0;
      b_lat     <= 5'd0;
      b_bank    <= 3'd0;
      b_row     <= '0;
      b_col     <= '0;
      ap_clr    <= 1'b0;
      ap_bank   <= 3'd0;
    end else begin
      BANK_OPEN <= bank_open_d;
      if (init_err || act_err || ref_err || rw_err) ERR <= 1'b1;
      ap_clr <= 1'b0;
      if (accept) begin
        busy   <= 1'b1;
        cnt    <= 5'd1;
        b_wr   <= (cmd == CMD_WR);
        b_ap   <= ADDR[10];
        b_lat  <= (cmd == CMD_WR) ? 5'(CWL) : 5'(CL);
        b_bank <= BA;
        b_row  <= open_row[BA];
        b_col  <= ADDR[COL_W-1:0] & ~COL_W'(3'b111);
      end else if (busy) begin
        cnt <= cnt + 5'd1;
        if (cnt == b_lat + 5'd7) begin
          busy    <= 1'b0;
          ap_clr  <= b_ap;
          ap_bank <= b_bank;
        end
      end
      if (in_window && !b_wr) begin
        DQ_OE  <= 1'b1;
        DQ_OUT <= mem[mem_addr];
      end else begin
        DQ_OE  <= 1'b0;
        DQ_OUT <= 8'd0;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (is_act && !act_err) open_row[BA] <= ADDR[ROW_W-1:0];
    if (in_window && b_wr) mem[mem_addr] <= DQ_IN;
  end
endmodule

// File: tb/tb_ddr3_mem_resp.sv
// Directed bench for ddr3_mem_resp. Commands are driven on the falling edge, and a
// monitor checks read beats against a cycle-tagged queue of expected bytes.
module tb_ddr3_mem_resp;
  localparam int CL  = 5;
  localparam int CWL = 5;

  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_ZQC = 4'b0110;
  localparam logic [3:0] C_NOP = 4'b0111;

  logic        cpu_clk = 1'b0;
  logic        RESET_N = 1'b1;
  logic        CKE_N = 1'b0;
  logic        CS_N, RAS_N, CAS_N, WE_N;
  logic [2:0]  BA;
  logic [14:0] ADDR;
  logic [7:0]  DQ_IN;
  logic [7:0]  DQ_OUT;
  logic        DQ_OE;
  logic        INIT_DONE;
  logic [7:0]  BANK_OPEN;
  logic        ERR;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int t_last = 0;

  typedef struct {
    logic [7:0] data;
    int         at;
  } beat_t;
  beat_t exp_q[$];

  ddr3_mem_resp #(.CL(CL), .CWL(CWL), .ROW_W(4), .COL_W(6)) dut (
    .cpu_clk(cpu_clk), .RESET_N(RESET_N), .CKE_N(CKE_N),
    .CS_N(CS_N), .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N),
    .BA(BA), .ADDR(ADDR), .DQ_IN(DQ_IN), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE),
    .INIT_DONE(INIT_DONE), .BANK_OPEN(BANK_OPEN), .ERR(ERR)
  );

  always #5 cpu_clk = ~cpu_clk;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  // A beat is due exactly on the cycle it was tagged with; anything else on the bus is a fault.
  always @(negedge cpu_clk) begin
    beat_t b;
    if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      b = exp_q.pop_front();
      tests++;
      if (DQ_OE !== 1'b1 || DQ_OUT !== b.data || b.at != cyc) begin
        fails++;
        $display("[TB] FAIL read beat: got oe=%0b data=0x%0h at cycle %0d, expected oe=1 data=0x%0h at cycle %0d",
                 DQ_OE, DQ_OUT, cyc, b.data, b.at);
      end
    end else begin
      tests++;
      if (DQ_OE !== 1'b0 || DQ_OUT !== 8'h00) begin
        fails++;
        $display("[TB] FAIL idle bus: got oe=%0b data=0x%0h at cycle %0d, expected oe=0 data=0x0",
                 DQ_OE, DQ_OUT, cyc);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] cmd, input logic [2:0] ba, input logic [14:0] addr);
    {CS_N, RAS_N, CAS_N, WE_N} = cmd;
    BA = ba;
    ADDR = addr;
    t_last = cyc + 1;
    @(negedge cpu_clk);
    {CS_N, RAS_N, CAS_N, WE_N} = C_NOP;
    BA = 3'd0;
    ADDR = 15'd0;
  endtask

  task automatic writeBurst(input logic [2:0] ba, input logic [14:0] addr, input logic [7:0] first);
    applyStimulus(C_WR, ba, addr);
    repeat (CWL - 1) @(negedge cpu_clk);
    for (int k = 0; k < 8; k++) begin
      DQ_IN = first + 8'(k);
      @(negedge cpu_clk);
    end
    DQ_IN = 8'hEE;
  endtask

  task automatic readBurst(input logic [2:0] ba, input logic [14:0] addr, input logic [7:0] first);
    applyStimulus(C_RD, ba, addr);
    for (int k = 0; k < 8; k++)
      exp_q.push_back('{data: first + 8'(k), at: t_last + CL + k});
  endtask

  task automatic doReset();
    RESET_N = 1'b0;
    CKE_N = 1'b0;
    repeat (2) @(negedge cpu_clk);
    RESET_N = 1'b1;
    CKE_N = 1'b1;
    @(negedge cpu_clk);
    applyStimulus(C_ZQC, 3'd0, 15'd0);
    checkOutput("init_done after zqc", 16'(INIT_DONE), 16'd1);
    checkOutput("err after reset", 16'(ERR), 16'd0);
  endtask

  initial begin
    {CS_N, RAS_N, CAS_N, WE_N} = C_NOP;
    BA = 3'd0;
    ADDR = 15'd0;
    DQ_IN = 8'hEE;
    #1 RESET_N = 1'b0;
    repeat (3) @(negedge cpu_clk);
    checkOutput("reset init_done", 16'(INIT_DONE), 16'd0);
    checkOutput("reset err", 16'(ERR), 16'd0);
    checkOutput("reset bank_open", 16'(BANK_OPEN), 16'h0000);
    checkOutput("reset dq_oe", 16'(DQ_OE), 16'd0);
    checkOutput("reset dq_out", 16'(DQ_OUT), 16'h0000);

    // Initialisation sequence and INIT-state command rules.
    RESET_N = 1'b1;
    @(negedge cpu_clk);
    applyStimulus(C_ACT, 3'd0, 15'd0);
    checkOutput("cke low in reset state", 16'(ERR), 16'd0);
    CKE_N = 1'b1;
    @(negedge cpu_clk);
    applyStimulus(C_MRS, 3'd0, 15'd0);
    checkOutput("mrs in init no err", 16'(ERR), 16'd0);
    checkOutput("init_done before zqc", 16'(INIT_DONE), 16'd0);
    CKE_N = 1'b0;
    applyStimulus(C_ACT, 3'd1, 15'd0);
    CKE_N = 1'b1;
    checkOutput("cke low act in init", 16'(ERR), 16'd0);
    applyStimulus(C_ACT, 3'd1, 15'd0);
    checkOutput("act before zqc err", 16'(ERR), 16'd1);
    checkOutput("act before zqc ignored", 16'(BANK_OPEN), 16'h0000);
    applyStimulus(C_ZQC, 3'd0, 15'd0);
    checkOutput("init_done after first zqc", 16'(INIT_DONE), 16'd1);

    // Write/read round trip, aligned column, in-flight burst isolation.
    doReset();
    applyStimulus(C_ACT, 3'd2, 15'd5);
    checkOutput("bank_open act b2", 16'(BANK_OPEN), 16'h0004);
    writeBurst(3'd2, 15'h008, 8'h10);
    writeBurst(3'd2, 15'h010, 8'hA0);
    checkOutput("writes no err", 16'(ERR), 16'd0);
    readBurst(3'd2, 15'h00B, 8'h10);
    applyStimulus(C_PRE, 3'd2, 15'd0);
    applyStimulus(C_ACT, 3'd2, 15'd3);
    checkOutput("pre/act during burst", 16'(BANK_OPEN), 16'h0004);
    checkOutput("pre/act during burst err", 16'(ERR), 16'd0);
    repeat (12) @(negedge cpu_clk);
    applyStimulus(C_PRE, 3'd2, 15'd0);
    applyStimulus(C_ACT, 3'd2, 15'd5);

    // Auto-precharge closes the bank one cycle after the last beat.
    readBurst(3'd2, 15'h408, 8'h10);
    repeat (12) @(negedge cpu_clk);
    checkOutput("ap bank open at last beat", 16'(BANK_OPEN), 16'h0004);
    @(negedge cpu_clk);
    checkOutput("ap bank closed after", 16'(BANK_OPEN), 16'h0000);
    applyStimulus(C_ACT, 3'd2, 15'd5);
    checkOutput("act after ap err", 16'(ERR), 16'd0);
    checkOutput("act after ap open", 16'(BANK_OPEN), 16'h0004);

    // Overlapping read rejected; read right after last beat accepted.
    readBurst(3'd2, 15'h008, 8'h10);
    repeat (2) @(negedge cpu_clk);
    applyStimulus(C_RD, 3'd2, 15'h010);
    checkOutput("overlapping rd err", 16'(ERR), 16'd1);
    repeat (9) @(negedge cpu_clk);
    readBurst(3'd2, 15'h010, 8'hA0);
    checkOutput("back-to-back rd err unchanged", 16'(ERR), 16'd1);
    repeat (13) @(negedge cpu_clk);

    // Refresh legality and precharge variants.
    doReset();
    applyStimulus(C_ACT, 3'd0, 15'd1);
    applyStimulus(C_ACT, 3'd2, 15'd5);
    checkOutput("two banks open", 16'(BANK_OPEN), 16'h0005);
    checkOutput("two banks open err", 16'(ERR), 16'd0);
    applyStimulus(C_REF, 3'd0, 15'd0);
    checkOutput("ref with open banks", 16'(ERR), 16'd1);
    applyStimulus(C_PRE, 3'd0, 15'h400);
    checkOutput("pre all", 16'(BANK_OPEN), 16'h0000);
    applyStimulus(C_REF, 3'd0, 15'd0);
    checkOutput("ref closed err unchanged", 16'(ERR), 16'd1);
    applyStimulus(C_ACT, 3'd0, 15'd1);
    applyStimulus(C_ACT, 3'd2, 15'd5);
    applyStimulus(C_PRE, 3'd0, 15'd0);
    checkOutput("pre single bank", 16'(BANK_OPEN), 16'h0004);
    applyStimulus(C_PRE, 3'd5, 15'd0);
    checkOutput("pre closed bank", 16'(BANK_OPEN), 16'h0004);

    // Read to a closed bank launches nothing.
    doReset();
    applyStimulus(C_RD, 3'd3, 15'h008);
    checkOutput("rd closed bank err", 16'(ERR), 16'd1);
    repeat (15) @(negedge cpu_clk);

    // ACT to an open bank keeps the original row.
    doReset();
    applyStimulus(C_ACT, 3'd2, 15'd5);
    applyStimulus(C_ACT, 3'd2, 15'd7);
    checkOutput("act open bank err", 16'(ERR), 16'd1);
    checkOutput("act open bank state", 16'(BANK_OPEN), 16'h0004);
    readBurst(3'd2, 15'h008, 8'h10);
    repeat (13) @(negedge cpu_clk);

    // CKE gating in READY, then reset in the middle of a read burst.
    doReset();
    applyStimulus(C_REF, 3'd0, 15'd0);
    checkOutput("ref all closed", 16'(ERR), 16'd0);
    CKE_N = 1'b0;
    applyStimulus(C_ACT, 3'd1, 15'd0);
    CKE_N = 1'b1;
    checkOutput("cke low act ignored", 16'(BANK_OPEN), 16'h0000);
    checkOutput("cke low act no err", 16'(ERR), 16'd0);
    applyStimulus(C_ACT, 3'd2, 15'd5);
    applyStimulus(C_REF, 3'd0, 15'd0);
    checkOutput("ref before abort", 16'(ERR), 16'd1);
    readBurst(3'd2, 15'h008, 8'h10);
    repeat (CL + 3) @(negedge cpu_clk);
    #2 RESET_N = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("abort dq_oe", 16'(DQ_OE), 16'd0);
    checkOutput("abort dq_out", 16'(DQ_OUT), 16'h0000);
    checkOutput("abort bank_open", 16'(BANK_OPEN), 16'h0000);
    checkOutput("abort err", 16'(ERR), 16'd0);
    checkOutput("abort init_done", 16'(INIT_DONE), 16'd0);
    repeat (3) @(negedge cpu_clk);

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge cpu_clk);
    checkOutput("scoreboard drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ddr3_mem_resp.md
DDR3_MEM_RESP -- requirements
Module: ddr3_mem_resp

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CL, 5, read latency in cpu_clk cycles from RD command to first read beat (legal range 2-15).
- CWL, 5, write latency in cpu_clk cycles from WR command to first write beat (legal range 1-15).
- ROW_W, 4, row bits stored (ADDR[ROW_W-1:0]).
- COL_W, 6, column bits stored (ADDR[COL_W-1:0]); minimum 3.
REQ-002 Ports, one per line: name, direction, width, meaning. One clock; reset asynchronous, active-low.
- cpu_clk, in, 1, sole clock; all sampling on its rising edge.
- RESET_N, in, 1, asynchronous active-low reset.
- CKE_N, in, 1, clock enable, active high despite name; commands are ignored while 0.
- CS_N / RAS_N / CAS_N / WE_N, in, 1 each, command bus.
- BA, in, 3, bank address.
- ADDR, in, 15, row (ACT) or column/AP (RD, WR, PRE).
- DQ_IN, in, 8, write data beat.
- DQ_OUT, out, 8, read data beat.
- DQ_OE, out, 1, high while DQ_OUT carries a valid read beat.
- INIT_DONE, out, 1, ZQ calibration seen; device accepts commands.
- BANK_OPEN, out, 8, per-bank open-row flag.
- ERR, out, 1, sticky protocol-violation flag.

Function
REQ-003 Command decode of {CS_N,RAS_N,CAS_N,WE_N}: 0000 MRS, 0001 REF, 0010 PRE, 0011 ACT, 0100 WR, 0101 RD, 0110 ZQC, 0111 NOP, 1xxx deselect (treated as NOP).
REQ-004 Top FSM states: RESET, INIT, READY. RESET -> INIT on the first cycle with RESET_N=1 and CKE_N=1; INIT -> READY on ZQC; READY holds until reset.
REQ-005 In INIT, MRS and NOP are accepted without effect; any other command sets ERR and is otherwise ignored.
REQ-006 ACT in READY opens bank BA, stores ADDR[ROW_W-1:0] as its open row, and sets BANK_OPEN[BA]; ACT to an already-open bank sets ERR and leaves the open row unchanged.
REQ-007 PRE with ADDR[10]=0 closes bank BA; with ADDR[10]=1 it closes all banks. PRE to a closed bank is legal (no-op).
REQ-008 REF is legal only when BANK_OPEN==0; otherwise it sets ERR. REF has no other effect.
REQ-009 WR/RD to a closed bank sets ERR and launches no burst.
REQ-010 Storage is 8 x 2^ROW_W x 2^COL_W bytes, indexed {BA, open row, column}. Contents are not reset.
REQ-011 Bursts are BL8, aligned: beat k (0-7) addresses column {ADDR[COL_W-1:3], k}; ADDR[2:0] is ignored.
REQ-012 WR accepted at cycle T: DQ_IN is sampled and stored on cycles T+CWL .. T+CWL+7, in beat order 0-7.
REQ-013 RD accepted at cycle T: DQ_OUT = beat k and DQ_OE=1 on cycle T+CL+k (k=0..7). Outside read beats, DQ_OE=0 and DQ_OUT=0.
REQ-014 One burst is outstanding at a time. A RD/WR issued between acceptance of a burst and its last beat sets ERR and is ignored. A RD/WR on the cycle after the last beat is accepted.
REQ-015 A burst uses the bank and row latched at command acceptance; ACT/PRE to any bank during a burst does not alter an in-flight burst.
REQ-016 Auto-precharge: RD/WR with ADDR[10]=1 clears BANK_OPEN[BA] on the cycle after the last beat. An ACT to that bank before then sets ERR.
REQ-017 While CKE_N=0 in INIT or READY, commands are ignored and no error is flagged. An in-flight burst continues regardless of CKE_N.
REQ-018 ERR is sticky and clears only on reset.

Reset
REQ-019 RESET_N=0 asynchronously forces state RESET, INIT_DONE=0, BANK_OPEN=0, ERR=0, DQ_OE=0, and DQ_OUT=0. Any in-flight burst is aborted and no further write beats are stored.
REQ-020 INIT_DONE=1 exactly while the state is READY.

Verification
REQ-021 Reset release, then ZQC -> INIT_DONE=1 on the next cycle; ACT before ZQC -> ERR=1.
REQ-022 ACT BA=2 row=5; WR col=0x08 (AP=0) at T with DQ_IN=0x10..0x17 on T+5..T+12; RD col=0x08 at T' -> DQ_OE=1 and DQ_OUT=0x10..0x17 on T'+5..T'+12.
REQ-023 RD with ADDR[10]=1 on bank 2 -> BANK_OPEN[2]=0 one cycle after the last beat; a following ACT BA=2 is accepted with ERR=0.
REQ-024 Second RD issued 3 cycles after the first -> ERR=1 and only 8 beats are driven. RD at first burst's last-beat+1 -> accepted, ERR unchanged.
REQ-025 BANK_OPEN=0x05 then REF -> ERR=1; PRE with ADDR[10]=1 -> BANK_OPEN=0x00; a following REF leaves ERR unchanged.
REQ-026 RESET_N low at the 4th read beat -> DQ_OE=0 immediately; BANK_OPEN=0, ERR=0, INIT_DONE=0.
